// File: rtl/sw_job_sequencer_if.sv
// Host stream, core launch/score and result handshake signals of sw_job_sequencer.
// master = sequencer side, slave = host/core/consumer side.
interface sw_job_sequencer_if #(
   parameter int SCORE_W = 7
);
   logic               host_valid;
   logic               host_ready;
   logic [7:0]         host_qry;
   logic [7:0]         host_db;
   logic               core_ready;
   logic               core_start;
   logic [7:0]         core_qry;
   logic [7:0]         core_db;
   logic               core_output_valid;
   logic [SCORE_W-1:0] core_score;
   logic               res_valid;
   logic               res_ready;
   logic [SCORE_W-1:0] res_score;
   logic               res_timeout;

   modport master (
      input  host_valid, host_qry, host_db, core_ready, core_output_valid, core_score, res_ready,
      output host_ready, core_start, core_qry, core_db, res_valid, res_score, res_timeout
   );

   modport slave (
      output host_valid, host_qry, host_db, core_ready, core_output_valid, core_score, res_ready,
      input  host_ready, core_start, core_qry, core_db, res_valid, res_score, res_timeout
   );
endinterface

// File: rtl/sw_job_sequencer.sv
// Job controller for the Smith-Waterman core: buffer one sequence pair, launch, stream, capture score.
// Optional watchdog on the COMPUTE phase is enabled by defining SW_TIMEOUT_EN.
module sw_job_sequencer #(
   parameter int SEQ_BYTES   = 4,
   parameter int SCORE_W     = 7,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic                clk,
   input  logic                rst,
   sw_job_sequencer_if.master  sif,
   output logic                busy,
   output logic [7:0]          job_cnt
);
   localparam int IDX_W = (SEQ_BYTES > 1) ? $clog2(SEQ_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_BYTES - 1);

   if (SEQ_BYTES < 1 || SEQ_BYTES > 16 || TIMEOUT_CYC < 2) begin : g_param_check
      $error("sw_job_sequencer: parameter outside legal range");
   end

   typedef enum logic [2:0] {
      S_LOAD,
      S_WAIT_RDY,
      S_START,
      S_STREAM,
      S_COMPUTE,
      S_RESULT
   } state_t;

   state_t             r_state, w_state_next;
   logic [IDX_W-1:0]   r_idx, w_idx_next;
   logic [7:0]         r_qry_buf [SEQ_BYTES];
   logic [7:0]         r_db_buf  [SEQ_BYTES];
   logic [SCORE_W-1:0] r_res_score, w_res_score_next;
   logic               r_res_timeout, w_res_timeout_next;
   logic [7:0]         r_job_cnt, w_job_cnt_next;
   logic               w_accept;
   logic               w_streaming;
   logic               w_wd_expired;

`ifdef SW_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   logic [WD_W-1:0] r_wd;

   // Held at zero outside COMPUTE so it always starts from 0 on entry.
   always_ff @(posedge clk) begin
      if (rst || r_state != S_COMPUTE) begin
         r_wd <= '0;
      end else begin
         r_wd <= r_wd + WD_W'(1);
      end
   end

   assign w_wd_expired = (r_wd == WD_LAST);
`else
   assign w_wd_expired = 1'b0;
`endif

   assign w_accept    = sif.host_valid && (r_state == S_LOAD);
   assign w_streaming = (r_state == S_START) || (r_state == S_STREAM);

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_qry_buf[r_idx] <= sif.host_qry;
         r_db_buf[r_idx]  <= sif.host_db;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_LOAD;
         r_idx         <= '0;
         r_res_score   <= '0;
         r_res_timeout <= 1'b0;
         r_job_cnt     <= '0;
      end else begin
         r_state       <= w_state_next;
         r_idx         <= w_idx_next;
         r_res_score   <= w_res_score_next;
         r_res_timeout <= w_res_timeout_next;
         r_job_cnt     <= w_job_cnt_next;
      end
   end

   // The single index serves both the load and the stream phase; it is 0 whenever a phase begins.
   always_comb begin
      w_state_next       = r_state;
      w_idx_next         = r_idx;
      w_res_score_next   = r_res_score;
      w_res_timeout_next = r_res_timeout;
      w_job_cnt_next     = r_job_cnt;
      case (r_state)
         S_LOAD: begin
            if (w_accept) begin
               if (r_idx == LAST_IDX) begin
                  w_idx_next   = '0;
                  w_state_next = S_WAIT_RDY;
               end else begin
                  w_idx_next = r_idx + IDX_W'(1);
               end
            end
         end
         S_WAIT_RDY: begin
            if (sif.core_ready) begin
               w_state_next = S_START;
            end
         end
         S_START: begin
            if (SEQ_BYTES == 1) begin
               w_state_next = S_COMPUTE;
            end else begin
               w_idx_next   = r_idx + IDX_W'(1);
               w_state_next = S_STREAM;
            end
         end
         S_STREAM: begin
            if (r_idx == LAST_IDX) begin
               w_idx_next   = '0;
               w_state_next = S_COMPUTE;
            end else begin
               w_idx_next = r_idx + IDX_W'(1);
            end
         end
         S_COMPUTE: begin
            // A score arriving on the watchdog's last cycle takes priority.
            if (sif.core_output_valid) begin
               w_res_score_next   = sif.core_score;
               w_res_timeout_next = 1'b0;
               w_state_next       = S_RESULT;
            end else if (w_wd_expired) begin
               w_res_score_next   = '0;
               w_res_timeout_next = 1'b1;
               w_state_next       = S_RESULT;
            end
         end
         S_RESULT: begin
            if (sif.res_ready) begin
               w_job_cnt_next = r_job_cnt + 8'd1;
               w_idx_next     = '0;
               w_state_next   = S_LOAD;
            end
         end
         default: begin
            w_state_next = S_LOAD;
            w_idx_next   = '0;
         end
      endcase
   end

   assign sif.host_ready  = (r_state == S_LOAD);
   assign sif.core_start  = (r_state == S_START);
   assign sif.core_qry    = w_streaming ? r_qry_buf[r_idx] : 8'd0;
   assign sif.core_db     = w_streaming ? r_db_buf[r_idx]  : 8'd0;
   assign sif.res_valid   = (r_state == S_RESULT);
   assign sif.res_score   = r_res_score;
   assign sif.res_timeout = r_res_timeout;
   assign busy            = (r_state != S_LOAD);
   assign job_cnt         = r_job_cnt;

endmodule

// File: tb/tb_sw_job_sequencer.sv
// Self-checking bench for sw_job_sequencer: directed scenarios plus randomized jobs
// checked against a job-level model (byte order, score/timeout outcome, job count).
module tb_sw_job_sequencer;
   localparam int SB = 4;
   localparam int SW = 7;
   localparam int TO = 16;

   logic       clk;
   logic       rst;
   logic       busy;
   logic [7:0] job_cnt;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_cnt  = 8'd0;
   int         job_no   = 0;

   sw_job_sequencer_if #(.SCORE_W(SW)) sif ();

   sw_job_sequencer #(
      .SEQ_BYTES   (SB),
      .SCORE_W     (SW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sif     (sif.master),
      .busy    (busy),
      .job_cnt (job_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete job. cmp_dly >= 0: strobe after cmp_dly silent COMPUTE cycles; cmp_dly < 0: no strobe.
   task automatic run_job(input logic [31:0] qw, input logic [31:0] dw, input int rdy_dly,
                          input int cmp_dly, input logic [SW-1:0] score, input int hold,
                          input string tag);
      logic          exp_to;
      logic [SW-1:0] exp_score;
      int            gap;
      int            n_wait;
      exp_to    = (cmp_dly < 0);
      exp_score = exp_to ? '0 : score;

      checks++;
      if (sif.host_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s idle: host_ready=%b busy=%b required 1/0", tag, sif.host_ready, busy);
      end
      for (int k = 0; k < SB; k++) begin
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            sif.host_valid = 1'b0;
            sif.host_qry   = 8'($urandom);
            sif.host_db    = 8'($urandom);
            tick();
         end
         sif.host_valid = 1'b1;
         sif.host_qry   = qw[8*k +: 8];
         sif.host_db    = dw[8*k +: 8];
         tick();
      end
      sif.host_valid = 1'b0;
      checks++;
      if (sif.host_ready !== 1'b0 || busy !== 1'b1 || sif.core_start !== 1'b0) begin
         failures++;
         $display("FAIL %s wait_rdy: host_ready=%b busy=%b core_start=%b required 0/1/0",
                  tag, sif.host_ready, busy, sif.core_start);
      end

      sif.core_ready = 1'b0;
      for (int i = 0; i < rdy_dly; i++) begin
         sif.core_output_valid = 1'($urandom);
         tick();
         checks++;
         if (sif.core_start !== 1'b0 || sif.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s core_busy cyc %0d: core_start=%b res_valid=%b required 0/0",
                     tag, i, sif.core_start, sif.res_valid);
         end
      end
      sif.core_output_valid = 1'b0;
      sif.core_ready        = 1'b1;
      tick();
      sif.core_ready = 1'($urandom);
      checks++;
      if (sif.core_start !== 1'b1 || sif.core_qry !== qw[7:0] || sif.core_db !== dw[7:0]) begin
         failures++;
         $display("FAIL %s start: core_start=%b qry=%h db=%h required 1 %h %h",
                  tag, sif.core_start, sif.core_qry, sif.core_db, qw[7:0], dw[7:0]);
      end
      for (int k = 1; k < SB; k++) begin
         tick();
         checks++;
         if (sif.core_start !== 1'b0 || sif.core_qry !== qw[8*k +: 8] || sif.core_db !== dw[8*k +: 8]) begin
            failures++;
            $display("FAIL %s stream byte %0d: core_start=%b qry=%h db=%h required 0 %h %h",
                     tag, k, sif.core_start, sif.core_qry, sif.core_db, qw[8*k +: 8], dw[8*k +: 8]);
         end
      end
      tick();
      sif.core_ready = 1'b0;
      checks++;
      if (sif.core_qry !== 8'd0 || sif.core_db !== 8'd0 || sif.core_start !== 1'b0 || sif.res_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s compute entry: qry=%h db=%h core_start=%b res_valid=%b required 00 00 0 0",
                  tag, sif.core_qry, sif.core_db, sif.core_start, sif.res_valid);
      end

      n_wait = exp_to ? (TO - 1) : cmp_dly;
      for (int i = 0; i < n_wait; i++) begin
         sif.core_score = SW'($urandom);
         tick();
         checks++;
         if (sif.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s early result at compute cyc %0d: res_valid=%b required 0", tag, i + 1, sif.res_valid);
         end
      end
      if (!exp_to) begin
         sif.core_output_valid = 1'b1;
         sif.core_score        = score;
      end
      tick();
      sif.core_output_valid = 1'b0;
      sif.core_score        = SW'($urandom);
      checks++;
      if (sif.res_valid !== 1'b1 || sif.res_score !== exp_score || sif.res_timeout !== exp_to) begin
         failures++;
         $display("FAIL %s result: valid=%b score=%h timeout=%b required 1 %h %b",
                  tag, sif.res_valid, sif.res_score, sif.res_timeout, exp_score, exp_to);
      end

      sif.res_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         sif.core_output_valid = 1'($urandom);
         sif.core_score        = SW'($urandom);
         tick();
         checks++;
         if (sif.res_valid !== 1'b1 || sif.res_score !== exp_score || sif.res_timeout !== exp_to) begin
            failures++;
            $display("FAIL %s hold cyc %0d: valid=%b score=%h timeout=%b required 1 %h %b",
                     tag, h, sif.res_valid, sif.res_score, sif.res_timeout, exp_score, exp_to);
         end
      end
      sif.core_output_valid = 1'b0;
      sif.res_ready         = 1'b1;
      tick();
      sif.res_ready = 1'b0;
      exp_cnt       = exp_cnt + 8'd1;
      checks++;
      if (sif.host_ready !== 1'b1 || sif.res_valid !== 1'b0 || job_cnt !== exp_cnt) begin
         failures++;
         $display("FAIL %s handshake: host_ready=%b res_valid=%b job_cnt=%0d required 1 0 %0d",
                  tag, sif.host_ready, sif.res_valid, job_cnt, exp_cnt);
      end
      job_no++;
      $display("job %0d %s: score=%h timeout=%b job_cnt=%0d", job_no, tag, exp_score, exp_to, job_cnt);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (sif.host_ready !== 1'b1 || busy !== 1'b0 || job_cnt !== 8'd0) begin
         failures++;
         $display("FAIL reset ctrl: host_ready=%b busy=%b job_cnt=%0d required 1 0 0", sif.host_ready, busy, job_cnt);
      end
      checks++;
      if (sif.core_start !== 1'b0 || sif.core_qry !== 8'd0 || sif.core_db !== 8'd0) begin
         failures++;
         $display("FAIL reset core: start=%b qry=%h db=%h required 0 00 00", sif.core_start, sif.core_qry, sif.core_db);
      end
      checks++;
      if (sif.res_valid !== 1'b0 || sif.res_score !== '0 || sif.res_timeout !== 1'b0) begin
         failures++;
         $display("FAIL reset result: valid=%b score=%h timeout=%b required 0 00 0",
                  sif.res_valid, sif.res_score, sif.res_timeout);
      end
      rst     = 1'b0;
      exp_cnt = 8'd0;
      $display("reset: job_cnt=%0d", job_cnt);
   endtask

   task automatic test_load_launch_and_hold();
      run_job(32'hFF00E41B, 32'hAA55D827, 0, 0, 7'h2A, 5, "load_launch");
   endtask

   task automatic test_core_busy();
      run_job(32'($urandom), 32'($urandom), 10, 2, SW'($urandom), 1, "core_busy");
   endtask

`ifdef SW_TIMEOUT_EN
   task automatic test_watchdog();
      run_job(32'($urandom), 32'($urandom), 1, -1, 7'h55, 2, "watchdog_expire");
      run_job(32'($urandom), 32'($urandom), 1, TO - 1, 7'h13, 2, "watchdog_race");
   endtask
`endif

   task automatic test_reset_mid_stream();
      logic [31:0] qw;
      logic [31:0] dw;
      qw = 32'($urandom);
      dw = 32'($urandom);
      sif.core_ready = 1'b1;
      for (int k = 0; k < SB; k++) begin
         sif.host_valid = 1'b1;
         sif.host_qry   = qw[8*k +: 8];
         sif.host_db    = dw[8*k +: 8];
         tick();
      end
      sif.host_valid = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (sif.core_qry !== qw[23:16] || sif.core_db !== dw[23:16]) begin
         failures++;
         $display("FAIL mid_stream byte2: qry=%h db=%h required %h %h", sif.core_qry, sif.core_db, qw[23:16], dw[23:16]);
      end
      rst = 1'b1;
      tick();
      rst            = 1'b0;
      sif.core_ready = 1'b0;
      exp_cnt        = 8'd0;
      checks++;
      if (sif.core_qry !== 8'd0 || sif.core_db !== 8'd0 || busy !== 1'b0 || sif.host_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_stream reset: qry=%h db=%h busy=%b host_ready=%b required 00 00 0 1",
                  sif.core_qry, sif.core_db, busy, sif.host_ready);
      end
      checks++;
      if (job_cnt !== 8'd0 || sif.res_score !== '0) begin
         failures++;
         $display("FAIL mid_stream clear: job_cnt=%0d res_score=%h required 0 00", job_cnt, sif.res_score);
      end
      for (int i = 0; i < 4; i++) begin
         sif.core_output_valid = 1'b1;
         sif.core_score        = SW'($urandom);
         tick();
         checks++;
         if (sif.res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL spurious strobe %0d: res_valid=%b busy=%b required 0 0", i, sif.res_valid, busy);
         end
      end
      sif.core_output_valid = 1'b0;
      $display("reset mid-stream: busy=%b host_ready=%b", busy, sif.host_ready);
   endtask

   task automatic test_random_jobs();
      for (int j = 0; j < 12; j++) begin
         run_job(32'($urandom), 32'($urandom), $urandom_range(0, 4), $urandom_range(0, 12),
                 SW'($urandom), $urandom_range(0, 3), "random");
      end
   endtask

   task automatic test_counter_wrap();
      logic [7:0] start_cnt;
      start_cnt = exp_cnt;
      for (int j = 0; j < 256; j++) begin
         run_job(32'($urandom), 32'($urandom), $urandom_range(0, 1), $urandom_range(0, 3),
                 SW'($urandom), $urandom_range(0, 1), "wrap");
      end
      checks++;
      if (job_cnt !== start_cnt) begin
         failures++;
         $display("FAIL counter wrap: job_cnt=%0d after 256 jobs required %0d", job_cnt, start_cnt);
      end
   endtask

   initial begin
      rst                   = 1'b1;
      sif.host_valid        = 1'b0;
      sif.host_qry          = 8'd0;
      sif.host_db           = 8'd0;
      sif.core_ready        = 1'b0;
      sif.core_output_valid = 1'b0;
      sif.core_score        = '0;
      sif.res_ready         = 1'b0;
      test_reset();
      test_load_launch_and_hold();
      test_core_busy();
`ifdef SW_TIMEOUT_EN
      test_watchdog();
`endif
      test_reset_mid_stream();
      test_random_jobs();
      test_counter_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sw_job_sequencer.md
# sw_job_sequencer

Host-side job controller for the Smith-Waterman alignment core (`sw`). It collects one query/database sequence pair from a byte-wide host stream and waits for the core to be idle. It then launches the core with a one-cycle start, streams the buffered bytes, and captures the score. The score is returned over a valid/ready result port. It sits between the pad-limited host interface and the core, inside the pad ring.

## Interface
- `SEQ_BYTES`, default 4: bytes per sequence per job. Each byte packs 4 bases at 2 bits each. Legal range 1–16.
- `SCORE_W`, default 7: score width. Matches core `score`.
- `TIMEOUT_CYC`, default 1023: watchdog limit, counted in COMPUTE cycles. Legal range ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `host_valid` in 1: host beat valid.
- `host_ready` out 1: sequencer accepts a beat.
- `host_qry` in 8: query byte.
- `host_db` in 8: database byte.
- `core_ready` in 1: core idle and able to start.
- `core_start` out 1: one-cycle launch pulse.
- `core_qry` out 8: query byte to core.
- `core_db` out 8: database byte to core.
- `core_output_valid` in 1: one-cycle score strobe from core.
- `core_score` in SCORE_W: core score.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumer ready.
- `res_score` out SCORE_W: captured score.
- `res_timeout` out 1: job ended by watchdog.
- `busy` out 1: high in every state except LOAD.
- `job_cnt` out 8: completed jobs, wraps 255→0.

## Operation
- **Buffer.** Two SEQ_BYTES×8 register arrays, one for query and one for database. A beat index counts 0..SEQ_BYTES-1.
- **LOAD** (reset state).
  - `host_ready`=1.
  - Each `host_valid&&host_ready` writes the pair at the current index and increments the index.
  - The beat at index SEQ_BYTES-1 moves the state to WAIT_RDY.
- **WAIT_RDY.** If `core_ready`=1, go to START. Otherwise hold.
- **START.**
  - Registered `core_start`=1 for exactly one cycle.
  - Byte 0 is presented on `core_qry`/`core_db`.
  - If SEQ_BYTES=1, next state is COMPUTE. Otherwise next state is STREAM.
- **STREAM.**
  - Bytes 1..SEQ_BYTES-1 are presented on consecutive cycles, no gaps.
  - Go to COMPUTE after the last byte.
- **Core data outside START/STREAM.** `core_qry`/`core_db` = 0.
- **COMPUTE.**
  - Wait for `core_output_valid`.
  - On the strobe, register `core_score` into `res_score`, clear `res_timeout`, and go to RESULT.
- **RESULT.**
  - `res_valid`=1. `res_score`/`res_timeout` are held stable until `res_valid&&res_ready`.
  - On that handshake: `job_cnt`+1 (mod 256), clear the index, go to LOAD.
- **Out-of-state strobes.** `core_output_valid` outside COMPUTE is ignored.
- **Reset.** `rst` in any state (including mid-STREAM) returns to LOAD on the next edge. All buffered data is discarded.
- **Reset values.**
  - `host_ready`=1.
  - 0: `core_start`, `core_qry`, `core_db`, `res_valid`, `res_score`, `res_timeout`, `busy`, `job_cnt`.

## Timing
- Last host beat accepted at cycle t: WAIT_RDY at t+1.
- `core_ready`=1 sampled at cycle w in WAIT_RDY: `core_start`=1 at w+1. Byte k appears at w+1+k.
- COMPUTE is entered at w+1+SEQ_BYTES.
- `core_output_valid` at cycle c in COMPUTE: `res_valid`=1 at c+1.
- Result handshake at cycle r: `host_ready`=1 at r+1.
- `host_ready` is combinational from state only. There is no path from `host_valid` to `host_ready`.
- Best-case throughput: SEQ_BYTES + 2 + SEQ_BYTES + core compute time + 1 cycles per job.

## Configuration
- **`SW_TIMEOUT_EN` defined:**
  - A watchdog counter of width clog2(TIMEOUT_CYC+1) clears on entry to COMPUTE and increments each COMPUTE cycle.
  - If TIMEOUT_CYC COMPUTE cycles elapse without `core_output_valid`, go to RESULT with `res_timeout`=1 and `res_score`=0.
  - If `core_output_valid` arrives in the same cycle the limit is reached, the score wins and `res_timeout`=0.
- **`SW_TIMEOUT_EN` undefined:** no counter. COMPUTE waits indefinitely. `res_timeout` is tied to 0.

## Test plan
All scenarios use SEQ_BYTES=4, TIMEOUT_CYC=16, SCORE_W=7.

- **Load and launch.**
  - Stimulus: reset; push qry 1B,E4,00,FF and db 27,D8,55,AA with `core_ready`=1.
  - Required: `host_ready` drops after the 4th beat; `core_start` is high for one cycle with 1B/27; then E4/D8, 00/55, FF/AA on the next 3 cycles; 00/00 after.
- **Result capture and hold.**
  - Stimulus: `core_output_valid` with `core_score`=2A; `res_ready`=0 for 5 cycles, then 1.
  - Required: `res_valid`=1 the next cycle with `res_score`=2A and `res_timeout`=0, stable for 5 cycles; on handshake `job_cnt` 0→1; `host_ready`=1 the following cycle.
- **Core busy.**
  - Stimulus: `core_ready`=0 for 10 cycles in WAIT_RDY, then 1.
  - Required: no `core_start` during the 10 cycles; `core_start` the cycle after `core_ready` rises.
- **Watchdog** (SW_TIMEOUT_EN).
  - Stimulus: no strobe.
  - Required: after 16 COMPUTE cycles, `res_valid`=1 with `res_timeout`=1 and `res_score`=0.
  - Stimulus: rerun with the strobe (score 13) on the 16th cycle.
  - Required: `res_score`=13, `res_timeout`=0.
- **Reset mid-stream and spurious strobe.**
  - Stimulus: assert `rst` during the 2nd STREAM byte.
  - Required: next cycle `core_qry`/`core_db`=0, `busy`=0, `host_ready`=1.
  - Stimulus: `core_output_valid` pulsed while in LOAD.
  - Required: `res_valid` stays 0.
- **Counter wrap.**
  - Stimulus: run 256 complete jobs.
  - Required: `job_cnt` goes 255→0 with no other side effect.
